mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM pipeline stage of the RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB register.
- It executes loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a byte-serial RAM port with a req/ready handshake.
- It holds the pipeline via stallreq until the access completes.
- Non-memory instructions pass straight through with zero added latency.

Parameters:
- RAM_ADDR_W, 32, width of ram_addr. Low RAM_ADDR_W bits of the effective address are used.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_reg_waddr  in  5  destination register from EX/MEM
- ex_we  in  1  register write enable from EX/MEM
- ex_reg_wdata  in  32  ALU result from EX/MEM
- ex_mem_op  in  5  [4:3]: 00 none, 01 load, 10 store, 11 treated as none; [2:0]: RISC-V funct3
- ex_mem_addr  in  32  effective byte address
- ex_mem_wdata  in  32  store data (rs2)
- mem_reg_waddr  out  5  to MEM/WB
- mem_we  out  1  to MEM/WB
- mem_reg_wdata  out  32  to MEM/WB
- stallreq  out  1  pipeline stall request to the stall controller
- ram_req  out  1  byte transfer request
- ram_we  out  1  1 = write byte, 0 = read byte
- ram_addr  out  RAM_ADDR_W  byte address
- ram_wdata  out  8  write byte
- ram_rdata  in  8  read byte, valid when ram_ready = 1
- ram_ready  in  1  transfer accepted/completed this cycle

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; all state changes on posedge clk.
- Reset values: state = IDLE, byte index = 0, load buffer = 0, ram_req = 0, stallreq = 0.
- Size: byte count N = 1 for funct3[1:0] = 00, 2 for 01, 4 for 10. funct3[1:0] = 11 is treated as a non-memory op.
- Address order: little-endian, byte k at ex_mem_addr + k (wraps mod 2^RAM_ADDR_W). Misaligned addresses are legal, with no exception.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no memory op: outputs pass through combinationally (mem_* = ex_*), stallreq = 0.
- IDLE, memory op present: stallreq = 1; next state ACCESS with index = 0.
- ACCESS:
  - ram_req = 1, ram_addr = ex_mem_addr + index, ram_we = store.
  - ram_wdata = ex_mem_wdata[8*index+7 : 8*index].
  - stallreq = 1.
  - On a cycle with ram_ready = 1: for loads, byte index is captured into buffer[8*index+7 : 8*index]; index increments.
  - If index = N-1 at that edge, next state is DONE.
  - Without ram_ready, all ram_* outputs stay stable.
- DONE (exactly 1 cycle): stallreq = 0, ram_req = 0; next state IDLE.
  - Load result: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW takes all 32 bits. It drives mem_reg_wdata; mem_we = ex_we, mem_reg_waddr = ex_reg_waddr.
  - Store: mem_* pass through.
- Stall timing: EX/MEM holds its inputs stable while stallreq = 1. It advances at the end of DONE, so the op is never re-issued.
- Latency with zero-wait RAM: stallreq is high for N+1 cycles (IDLE + N ACCESS); result is valid in the DONE cycle.
- Each wait cycle (ram_ready = 0) adds one cycle.
- Reset mid-access: the next edge returns to IDLE, ram_req = 0 and the buffer is cleared. Partial stores are not rolled back.
- Buffer clearing: the buffer is cleared on entry to ACCESS, so a short load never sees stale upper bytes.

Test Plan:
- Pass-through: ex_mem_op = 0, ex_we = 1, ex_reg_waddr = 5, ex_reg_wdata = 0x12345678 -> same cycle mem_we = 1, mem_reg_waddr = 5, mem_reg_wdata = 0x12345678; stallreq = 0; ram_req never high.
- LW at 0x100, RAM bytes 78,56,34,12, ready always 1 -> addrs 0x100..0x103 in order; stallreq high 5 cycles; DONE mem_reg_wdata = 0x12345678.
- LB at 0x20, byte 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LH at 0x21, bytes 0x34,0xF2 -> 0xFFFFF234; LHU -> 0x0000F234.
- SH at 0x103, wdata 0xAABBCCDD, ready low 2 cycles before each ack -> writes 0xDD@0x103 then 0xCC@0x104; ram_* stable while waiting; stallreq high 7 cycles.
- Back-to-back SW then LW to the same address with a ready-always RAM -> LW returns the stored word; no duplicate byte transfers.
- rst asserted during the 3rd ACCESS cycle of an LW -> next cycle ram_req = 0, stallreq = 0, state IDLE; a subsequent LB completes normally.

Source files
------------

// File: rtl/mem_access.sv
// MEM pipeline stage: executes byte-serial loads/stores over a req/ready RAM port,
// stalling the pipeline until the access completes; other ops pass straight through.
module mem_access #(
  parameter int RAM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            ex_reg_waddr,
  input  logic                  ex_we,
  input  logic [31:0]           ex_reg_wdata,
  input  logic [4:0]            ex_mem_op,
  input  logic [31:0]           ex_mem_addr,
  input  logic [31:0]           ex_mem_wdata,
  output logic [4:0]            mem_reg_waddr,
  output logic                  mem_we,
  output logic [31:0]           mem_reg_wdata,
  output logic                  stallreq,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  input  logic                  ram_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [31:0] load_buf;
  logic [31:0] load_result;

  logic [1:0]  op_kind;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  last_idx;
  logic [4:0]  bit_pos;

  // funct3[1:0] = 11 and op kind 11 are not memory accesses and take the bypass path
  always_comb begin
    op_kind     = ex_mem_op[4:3];
    op_size     = ex_mem_op[1:0];
    op_unsigned = ex_mem_op[2];
    is_load     = (op_kind == 2'b01) && (op_size != 2'b11);
    is_store    = (op_kind == 2'b10) && (op_size != 2'b11);
    is_mem      = is_load || is_store;
    last_idx    = (op_size == 2'b10) ? 2'd3 : op_size;
    bit_pos     = {idx, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (is_mem) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (ram_ready && (idx == last_idx)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Buffer is cleared on the way into ACCESS so short loads never see stale upper bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 2'd0;
      load_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            idx      <= 2'd0;
            load_buf <= 32'd0;
          end
        end
        ACCESS: begin
          if (ram_ready) begin
            if (is_load) begin
              load_buf[bit_pos +: 8] <= ram_rdata;
            end
            idx <= idx + 2'd1;
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

  always_comb begin
    case (op_size)
      2'b00:   load_result = {{24{~op_unsigned & load_buf[7]}}, load_buf[7:0]};
      2'b01:   load_result = {{16{~op_unsigned & load_buf[15]}}, load_buf[15:0]};
      default: load_result = load_buf;
    endcase
  end

  always_comb begin
    mem_reg_waddr = ex_reg_waddr;
    mem_we        = ex_we;
    mem_reg_wdata = ex_reg_wdata;
    stallreq      = 1'b0;
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = 8'd0;
    case (state)
      IDLE: begin
        stallreq = is_mem;
      end
      ACCESS: begin
        stallreq  = 1'b1;
        ram_req   = 1'b1;
        ram_we    = is_store;
        ram_addr  = ex_mem_addr[RAM_ADDR_W-1:0] + RAM_ADDR_W'(idx);
        ram_wdata = ex_mem_wdata[bit_pos +: 8];
      end
      DONE: begin
        if (is_load) begin
          mem_reg_wdata = load_result;
        end
      end
      default: begin
        stallreq = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus random loads/stores
// checked against a byte-array reference model with a configurable-wait RAM.
module tb_mem_access;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_reg_waddr;
  logic        ex_we;
  logic [31:0] ex_reg_wdata;
  logic [4:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wdata;
  logic [4:0]  mem_reg_waddr;
  logic        mem_we;
  logic [31:0] mem_reg_wdata;
  logic        stallreq;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ready;

  logic [7:0]  mem [4096];
  logic [7:0]  ref_mem [4096];
  xfer_t       xlog [$];
  int          ram_wait;
  int          wait_left;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_data;

  int          errors = 0;
  int          checks = 0;

  mem_access #(.RAM_ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_reg_waddr (ex_reg_waddr),
    .ex_we        (ex_we),
    .ex_reg_wdata (ex_reg_wdata),
    .ex_mem_op    (ex_mem_op),
    .ex_mem_addr  (ex_mem_addr),
    .ex_mem_wdata (ex_mem_wdata),
    .mem_reg_waddr(mem_reg_waddr),
    .mem_we       (mem_we),
    .mem_reg_wdata(mem_reg_wdata),
    .stallreq     (stallreq),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ready    (ram_ready)
  );

  always #5 clk = ~clk;

  // RAM acks after ram_wait low cycles per byte and logs every completed transfer
  assign ram_ready = ram_req && (wait_left == 0);
  assign ram_rdata = mem[ram_addr[11:0]];

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_req && ram_ready && ram_we) begin
      mem[ram_addr[11:0]] <= ram_wdata;
    end
    if (ram_req && ram_ready) begin
      xlog.push_back('{ram_addr, ram_we, (ram_we ? ram_wdata : ram_rdata)});
    end
    if (!ram_req || ram_ready) begin
      wait_left <= ram_wait;
    end else begin
      wait_left <= wait_left - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] data);
    ex_mem_op = 5'd0;
    bd_we     = 1'b1;
    bd_addr   = addr[11:0];
    bd_data   = data;
    ref_mem[addr[11:0]] = data;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  // Issues one EX/MEM op (called just after a rising edge) and checks it to completion
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input int waitc, input logic we, input logic [4:0] waddr,
                               input logic [31:0] alu, input string tag);
    int          n;
    int          base;
    int          stall_cnt;
    int          got;
    bit          is_load;
    bit          is_store;
    bit          held;
    bit          timed_out;
    longint      val;
    logic [31:0] exp_wdata;
    logic [31:0] h_addr;
    logic        h_we;
    logic [7:0]  h_wdata;
    logic [7:0]  exp_byte;
    logic [11:0] a;
    xfer_t       e;

    is_load  = (op[4:3] == 2'b01) && (op[1:0] != 2'b11);
    is_store = (op[4:3] == 2'b10) && (op[1:0] != 2'b11);
    n = (op[1:0] == 2'b00) ? 1 : ((op[1:0] == 2'b01) ? 2 : 4);

    ram_wait     = waitc;
    ex_mem_op    = op;
    ex_mem_addr  = addr;
    ex_mem_wdata = sdata;
    ex_we        = we;
    ex_reg_waddr = waddr;
    ex_reg_wdata = alu;
    base = xlog.size();

    stall_cnt = 0;
    held      = 1'b0;
    timed_out = 1'b1;
    h_addr    = '0;
    h_we      = 1'b0;
    h_wdata   = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (held) begin
        checkOutput({tag, "_hold_req"}, 32'(ram_req), 32'd1);
        checkOutput({tag, "_hold_addr"}, ram_addr, h_addr);
        checkOutput({tag, "_hold_we"}, 32'(ram_we), 32'(h_we));
        checkOutput({tag, "_hold_wdata"}, 32'(ram_wdata), 32'(h_wdata));
      end
      held    = ram_req && !ram_ready;
      h_addr  = ram_addr;
      h_we    = ram_we;
      h_wdata = ram_wdata;
      if (!stallreq) begin
        timed_out = 1'b0;
        break;
      end
      stall_cnt++;
    end
    checkOutput({tag, "_timeout"}, 32'(timed_out), 32'd0);
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt),
                (is_load || is_store) ? 32'(1 + n * (1 + waitc)) : 32'd0);

    if (is_load) begin
      val = 0;
      for (int k = 0; k < n; k++) begin
        a = 12'(addr + 32'(k));
        val = val + (longint'(ref_mem[a]) << (8 * k));
      end
      if (!op[2] && n < 4 && val >= (64'd1 << (8 * n - 1))) begin
        val = val - (64'd1 << (8 * n));
      end
      exp_wdata = 32'(val);
    end else begin
      exp_wdata = alu;
    end
    checkOutput({tag, "_wdata"}, mem_reg_wdata, exp_wdata);
    checkOutput({tag, "_we"}, 32'(mem_we), 32'(we));
    checkOutput({tag, "_waddr"}, 32'(mem_reg_waddr), 32'(waddr));
    checkOutput({tag, "_ram_req_end"}, 32'(ram_req), 32'd0);

    @(posedge clk);
    #1;
    got = xlog.size() - base;
    checkOutput({tag, "_xfer_count"}, 32'(got), (is_load || is_store) ? 32'(n) : 32'd0);
    for (int k = 0; k < n && k < got; k++) begin
      e = xlog[base + k];
      a = 12'(addr + 32'(k));
      exp_byte = is_store ? 8'((sdata >> (8 * k)) & 32'hFF) : ref_mem[a];
      checkOutput({tag, "_xfer_addr"}, e.addr, addr + 32'(k));
      checkOutput({tag, "_xfer_we"}, 32'(e.we), 32'(is_store));
      checkOutput({tag, "_xfer_data"}, 32'(e.data), 32'(exp_byte));
    end
    if (is_store) begin
      for (int k = 0; k < n; k++) begin
        a = 12'(addr + 32'(k));
        ref_mem[a] = 8'((sdata >> (8 * k)) & 32'hFF);
      end
    end
  endtask

  initial begin
    logic [4:0]  rop;
    logic [2:0]  f3;
    int          kind;

    rst          = 1'b1;
    ex_reg_waddr = '0;
    ex_we        = 1'b0;
    ex_reg_wdata = '0;
    ex_mem_op    = '0;
    ex_mem_addr  = '0;
    ex_mem_wdata = '0;
    ram_wait     = 0;
    bd_we        = 1'b0;
    bd_addr      = '0;
    bd_data      = '0;

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_stallreq", 32'(stallreq), 32'd0);
    checkOutput("reset_ram_req", 32'(ram_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] pass-through");
    applyStimulus(5'b00000, 32'h0, 32'h0, 0, 1'b1, 5'd5, 32'h12345678, "pass");
    applyStimulus(5'b11010, 32'h100, 32'h0, 0, 1'b1, 5'd7, 32'hCAFEF00D, "op11_pass");
    applyStimulus(5'b01011, 32'h100, 32'h0, 0, 1'b0, 5'd9, 32'h0BADBEEF, "f3_11_pass");

    $display("[TB] directed loads");
    poke(32'h100, 8'h78);
    poke(32'h101, 8'h56);
    poke(32'h102, 8'h34);
    poke(32'h103, 8'h12);
    applyStimulus(5'b01010, 32'h100, 32'h0, 0, 1'b1, 5'd3, 32'h0, "lw");
    poke(32'h20, 8'h80);
    poke(32'h21, 8'h34);
    poke(32'h22, 8'hF2);
    applyStimulus(5'b01000, 32'h20, 32'h0, 0, 1'b1, 5'd4, 32'h0, "lb");
    applyStimulus(5'b01100, 32'h20, 32'h0, 0, 1'b1, 5'd4, 32'h0, "lbu");
    applyStimulus(5'b01001, 32'h21, 32'h0, 1, 1'b1, 5'd6, 32'h0, "lh");
    applyStimulus(5'b01101, 32'h21, 32'h0, 0, 1'b1, 5'd6, 32'h0, "lhu");

    $display("[TB] directed stores");
    applyStimulus(5'b10001, 32'h103, 32'hAABBCCDD, 2, 1'b0, 5'd0, 32'h00000106, "sh_wait");
    applyStimulus(5'b10010, 32'h300, 32'h8899AABB, 0, 1'b0, 5'd0, 32'h300, "sw_b2b");
    applyStimulus(5'b01010, 32'h300, 32'h0, 0, 1'b1, 5'd11, 32'h0, "lw_b2b");
    applyStimulus(5'b01000, 32'h100, 32'h0, 0, 1'b1, 5'd12, 32'h0, "lb_after_lw");

    $display("[TB] address wrap");
    poke(32'hFFFFFFFF, 8'h01);
    poke(32'h00000000, 8'h80);
    applyStimulus(5'b01001, 32'hFFFFFFFF, 32'h0, 0, 1'b1, 5'd13, 32'h0, "lh_wrap");

    $display("[TB] reset mid-access");
    ram_wait     = 0;
    ex_mem_op    = 5'b01010;
    ex_mem_addr  = 32'h100;
    ex_we        = 1'b1;
    ex_reg_waddr = 5'd2;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rst_mid_req_before", 32'(ram_req), 32'd1);
    checkOutput("rst_mid_addr_before", ram_addr, 32'h102);
    rst       = 1'b1;
    ex_mem_op = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_mid_ram_req", 32'(ram_req), 32'd0);
    checkOutput("rst_mid_stallreq", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(5'b01000, 32'h20, 32'h0, 0, 1'b1, 5'd8, 32'h0, "lb_after_rst");

    $display("[TB] random");
    for (int i = 0; i < 64; i++) begin
      poke(32'h200 + 32'(i), 8'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 8));
      case (kind)
        0: f3 = 3'd0;
        1: f3 = 3'd1;
        2: f3 = 3'd2;
        3: f3 = 3'd4;
        4: f3 = 3'd5;
        5: f3 = 3'd0;
        6: f3 = 3'd1;
        default: f3 = 3'd2;
      endcase
      if (kind <= 4) begin
        rop = {2'b01, f3};
      end else if (kind <= 7) begin
        rop = {2'b10, f3};
      end else begin
        rop = 5'b00000;
      end
      applyStimulus(rop, 32'h200 + 32'($urandom_range(0, 60)), $urandom,
                    int'($urandom_range(0, 2)), 1'($urandom), 5'($urandom), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
